// File: rtl/random_delay_timer_pkg.sv
// random_delay_timer_pkg: shared state encoding and widths for the reaction-timer delay path
package random_delay_timer_pkg;
  localparam int RNG_WIDTH = 14;
  localparam int CLKS_PER_MS_DEFAULT = 100000;
  typedef enum logic [2:0] {
    IDLE,
    REQ,
    CAPTURE,
    WAIT,
    GO,
    DONE,
    FALSE_START
  } state_e;
endpackage

// File: rtl/ms_tick_prescaler.sv
// ms_tick_prescaler: one-cycle tick every CLKS_PER_MS cycles, restarted from zero by clear
module ms_tick_prescaler
  import random_delay_timer_pkg::*;
#(
  parameter int CLKS_PER_MS = CLKS_PER_MS_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);
  localparam int CW = CLKS_PER_MS > 1 ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_MS - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    tick = !clear && cnt_q == LAST;
    cnt_d = (clear || tick) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/random_delay_timer.sv
// random_delay_timer: requests an LFSR value, counts a bounded random ms delay, then raises go
module random_delay_timer
  import random_delay_timer_pkg::*;
#(
  parameter int CLKS_PER_MS  = CLKS_PER_MS_DEFAULT,
  parameter int MIN_DELAY_MS = 1000,
  parameter int RANGE_BITS   = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 button,
  output logic                 rng_enable,
  input  logic [RNG_WIDTH-1:0] random_value,
  output logic                 go,
  output logic                 go_pulse,
  output logic                 false_start,
  output logic                 busy,
  output logic [RNG_WIDTH-1:0] delay_ms
);
  localparam logic [RNG_WIDTH-1:0] RANGE_MASK = RNG_WIDTH'((1 << RANGE_BITS) - 1);
  localparam logic [RNG_WIDTH-1:0] MIN_DELAY  = RNG_WIDTH'(MIN_DELAY_MS);
  state_e state_q, state_d;
  logic start_prev_q, button_prev_q;
  logic [RNG_WIDTH-1:0] ms_cnt_q, ms_cnt_d, delay_ms_q, delay_ms_d;
  logic rng_enable_q, rng_enable_d, go_q, go_d, go_pulse_q, go_pulse_d;
  logic false_start_q, false_start_d, busy_q, busy_d;
  logic tick, start_rise, button_rise, expired;
  ms_tick_prescaler #(.CLKS_PER_MS(CLKS_PER_MS)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (state_q != WAIT),
    .tick  (tick)
  );
  // Leaving WAIT on the tick that takes the counter to zero puts GO exactly delay*CLKS_PER_MS cycles in
  always_comb begin
    start_rise  = start && !start_prev_q;
    button_rise = button && !button_prev_q;
    expired     = ms_cnt_q == '0 || (tick && ms_cnt_q == RNG_WIDTH'(1));
    state_d     = state_q;
    case (state_q)
      IDLE, DONE, FALSE_START: if (start_rise) state_d = REQ;
      REQ:                     state_d = CAPTURE;
      CAPTURE:                 state_d = WAIT;
      WAIT:                    state_d = button_rise ? FALSE_START : expired ? GO : WAIT;
      GO:                      if (button_rise) state_d = DONE;
      default:                 state_d = IDLE;
    endcase
    delay_ms_d    = state_q == CAPTURE ? MIN_DELAY + (random_value & RANGE_MASK) : delay_ms_q;
    ms_cnt_d      = state_q == CAPTURE ? delay_ms_d :
                    (state_q == WAIT && tick && ms_cnt_q != '0) ? ms_cnt_q - 1'b1 : ms_cnt_q;
    rng_enable_d  = state_d == REQ;
    go_d          = state_d == GO;
    go_pulse_d    = state_d == GO && state_q != GO;
    false_start_d = state_d == FALSE_START;
    busy_d        = state_d inside {REQ, CAPTURE, WAIT};
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q       <= IDLE;
      start_prev_q  <= 1'b0;
      button_prev_q <= 1'b0;
      ms_cnt_q      <= '0;
      delay_ms_q    <= '0;
      rng_enable_q  <= 1'b0;
      go_q          <= 1'b0;
      go_pulse_q    <= 1'b0;
      false_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      start_prev_q  <= start;
      button_prev_q <= button;
      ms_cnt_q      <= ms_cnt_d;
      delay_ms_q    <= delay_ms_d;
      rng_enable_q  <= rng_enable_d;
      go_q          <= go_d;
      go_pulse_q    <= go_pulse_d;
      false_start_q <= false_start_d;
      busy_q        <= busy_d;
    end
  assign rng_enable  = rng_enable_q;
  assign go          = go_q;
  assign go_pulse    = go_pulse_q;
  assign false_start = false_start_q;
  assign busy        = busy_q;
  assign delay_ms    = delay_ms_q;
endmodule

// File: tb/tb_random_delay_timer.sv
// tb_random_delay_timer: timestamped event scoreboard against a trial-level timing model
module tb_random_delay_timer;
  localparam int N = 4, MIN = 2, RB = 3;
  localparam int MASK = (1 << RB) - 1;
  localparam int EV_RNG = 0, EV_GO = 1, EV_FS = 2, EV_END = 3;
  typedef struct {
    int kind;
    int cyc;
    int val;
  } ev_t;
  logic clk = 0, reset = 1, start = 0, button = 0;
  logic [13:0] random_value = 0, gen_val = 0;
  logic rng_enable, go, go_pulse, false_start, busy;
  logic [13:0] delay_ms;
  int cyc = 0, vectors = 0, miscompares = 0;
  logic go_prev = 0, fs_prev = 0;
  ev_t exp_q[$];

  random_delay_timer #(.CLKS_PER_MS(N), .MIN_DELAY_MS(MIN), .RANGE_BITS(RB)) dut (
    .clk(clk), .reset(reset), .start(start), .button(button), .rng_enable(rng_enable),
    .random_value(random_value), .go(go), .go_pulse(go_pulse), .false_start(false_start),
    .busy(busy), .delay_ms(delay_ms)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Generator model: value appears one cycle after enable is sampled, then turns to junk
  always @(negedge clk)
    if (rng_enable && !reset) begin
      @(posedge clk);
      #1 random_value = gen_val;
      @(posedge clk);
      #1 random_value = 14'($urandom);
    end

  function automatic string ev_name(input int k);
    return k == EV_RNG ? "rng_enable" : k == EV_GO ? "go_pulse" : k == EV_FS ? "false_start" : "go_fall";
  endfunction

  function automatic void push_ev(input int k, input int c, input int v);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.val  = v;
    exp_q.push_back(e);
  endfunction

  // Trial model: start seen in cycle p, delay d ms, button rise seen in cycle q
  function automatic void expect_trial(input int p, input int d, input int q);
    int w, g;
    w = p + 3;
    g = w + (d * N > 0 ? d * N : 1);
    push_ev(EV_RNG, p + 1, -1);
    if (q >= w && q < g) push_ev(EV_FS, q + 1, d);
    else begin
      push_ev(EV_GO, g, d);
      if (q >= g) push_ev(EV_END, q + 1, d);
    end
  endfunction

  task automatic check_ev(input int kind, input int val);
    ev_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_%s: got event at cycle %0d, required no event", ev_name(kind), cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || (e.val >= 0 && e.val != val)) begin
        miscompares++;
        $display("FAIL event: got %s cycle=%0d delay_ms=%0d, required %s cycle=%0d delay_ms=%0d",
                 ev_name(kind), cyc, val, ev_name(e.kind), e.cyc, e.val);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      go_prev = 0;
      fs_prev = 0;
    end else begin
      vectors++;
      if ((go_pulse && (!go || go_prev)) || (go && !go_prev && !go_pulse) ||
          (go && (busy || false_start)) || (false_start && busy)) begin
        miscompares++;
        $display("FAIL invariant cycle=%0d: got go=%b go_pulse=%b false_start=%b busy=%b",
                 cyc, go, go_pulse, false_start, busy);
      end
      if (rng_enable) check_ev(EV_RNG, int'(delay_ms));
      if (go_pulse) check_ev(EV_GO, int'(delay_ms));
      if (false_start && !fs_prev) check_ev(EV_FS, int'(delay_ms));
      if (!go && go_prev) check_ev(EV_END, int'(delay_ms));
      go_prev = go;
      fs_prev = false_start;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string name);
    vectors++;
    if ({rng_enable, go, go_pulse, false_start, busy, delay_ms} !== '0) begin
      miscompares++;
      $display("FAIL %s: got rng=%b go=%b pulse=%b fs=%b busy=%b delay_ms=%0d, required all 0",
               name, rng_enable, go, go_pulse, false_start, busy, delay_ms);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 reset = 1;
    exp_q.delete();
    start  = 0;
    button = 0;
    #1 check_zero("reset_async");
    repeat (2) @(posedge clk);
    #2 reset = 0;
    #1 check_zero("reset_release");
    for (int i = 0; i < 6; i++) begin
      tick();
      button = (i % 2 == 0);
    end
    tick();
    check_zero("idle_button");
  endtask

  task automatic trial(input logic [13:0] rv, input int boff, input bit poke, input bit held);
    int p, d, q, stop;
    start  = 0;
    button = held;
    tick();
    tick();
    gen_val = rv;
    start   = 1;
    p       = cyc;
    d       = MIN + (int'(rv) & MASK);
    q       = p + 3 + boff;
    expect_trial(p, d, q);
    stop = q + 3;
    while (cyc < stop) begin
      tick();
      start  = poke && cyc <= q && ((cyc - p) % 2 == 0);
      button = held ? (cyc != q - 1) : (cyc >= q);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL missing_events: got %0d pending (first %s at cycle %0d), required 0",
               exp_q.size(), ev_name(exp_q[0].kind), exp_q[0].cyc);
      exp_q.delete();
    end
  endtask

  initial begin
    int p, d;
    repeat (3) @(posedge clk);
    #1 check_zero("reset_hold");
    #2 reset = 0;
    tick();
    check_zero("after_release");
    do_reset();
    trial(14'h2005, 30, 0, 0);
    trial(14'h2005, 10, 0, 0);
    trial(14'h0000, 7, 0, 0);
    trial(14'h2005, 31, 1, 0);
    trial(14'h0006, 34, 0, 1);
    trial(14'h0003, 5, 0, 1);
    tick();
    start = 0;
    button = 0;
    tick();
    gen_val = 14'h0123;
    start = 1;
    p = cyc;
    push_ev(EV_RNG, p + 1, -1);
    repeat (8) tick();
    do_reset();
    trial(14'h3FFF, 37, 0, 0);
    for (int i = 0; i < 24; i++) begin
      gen_val = 14'($urandom);
      d = MIN + (int'(gen_val) & MASK);
      trial(gen_val, int'($urandom_range(0, d * N + 5)), 1'($urandom), 1'($urandom));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
